id_ex_stage_reg: RTL
====================

Name: id_ex_stage_reg

Overview:
- ID/EX boundary register and consumer of the decoder's control bundle.
- Latches the control bundle, operands, immediate and register indices from ID into EX.
- Detects load-use hazards and inserts a one-cycle bubble while stalling PC and IF/ID.
- Squashes the ID instruction when EX resolves a taken branch.

Parameters:
- DATA_W, 32, operand/immediate/PC width
- REG_AW, 5, register index width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- hold  in  1  global freeze (memory wait); all state retained
- flush  in  1  taken branch resolved in EX; squash the ID instruction
- id_valid  in  1  ID holds a real instruction
- id_reg_dst, id_alu_src, id_mem_read, id_mem_write, id_mem_to_reg, id_reg_write, id_branch  in  1 each  decoder control bundle
- id_alu_op  in  2  ALU operation class
- id_rs, id_rt, id_rd  in  REG_AW  register indices
- id_rdata1, id_rdata2, id_imm, id_pc4  in  DATA_W  operands, sign-extended immediate, PC+4
- stall  out  1  combinational; freeze PC and IF/ID
- ex_valid  out  1  registered valid
- ex_reg_dst … ex_branch, ex_alu_op  out  as inputs  registered control bundle
- ex_rs, ex_rt, ex_rd  out  REG_AW  registered indices
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered data

Behaviour:
- Reset (rst_n=0 at posedge):
  - all ex_* outputs go to 0; ex_alu_op = ALU_OP_ADD (2'b00).
  - stall is masked to 0 while rst_n=0.
  - Reset mid-stall discards the pending hazard.
- Hazard:
  - uses_rt = !id_alu_src | id_mem_write.
  - hazard = id_valid & ex_valid & ex_mem_read & ex_rt!=0 & (ex_rt==id_rs | (uses_rt & ex_rt==id_rt)).
- stall = hazard & !flush & rst_n. It is asserted in the same cycle as the hazard (0-cycle latency).
- Register update per posedge, in priority order:
  1. rst_n=0 → reset values.
  2. hold=1 → all ex_* retain their values.
  3. flush=1 → bubble. A bubble is ex_valid=0 and every control bit 0; data fields are don't-care and are loaded from ID.
  4. hazard=1 → bubble; ID contents stay upstream because of stall.
  5. Otherwise → load all ID fields. ex_valid=id_valid; if id_valid=0, control bits load as 0.
- Stall duration:
  - Exactly one bubble per load-use, because the bubble clears ex_mem_read.
  - Under hold, stall stays high combinationally and no bubble is counted twice.
- Simultaneous events:
  - flush+hazard: flush wins and stall=0.
  - hold+flush: hold wins. The upstream stage must keep flush asserted until hold drops.
- The register is never write-enabled by the control bundle itself. A decoded reg_write=1 with id_valid=0 must produce ex_reg_write=0.

Optional Feature:
- Macro: MIPS_HAZARD_CNT_EN.
- With the macro:
  - Adds output bubble_cnt [15:0].
  - Increments on every posedge where a hazard bubble is inserted (case 4 only, not flush).
  - Saturates at 16'hFFFF and resets to 0.
- Without the macro: the port and logic are absent; behaviour is otherwise identical.

Decomposition:
- mips_pkg.vh holds the shared constants:
  - ALU_OP_ADD/SUB/RTYPE/IMM encodings
  - REG_AW and the REG_ZERO index
  - CTRL_W (9) and bit positions of the control bundle, for packing/unpacking
- Sub-module load_use_detect is combinational and produces hazard from the ID/EX indices and flags. The parent holds all registers.

Test Plan:
- Reset, then drive R-type ADD (rs=1, rt=2, rd=3, id_valid=1) → next cycle ex_reg_dst=1, ex_alu_op=2'b10, ex_reg_write=1, ex_rd=3, stall=0.
- LW rt=5 in EX (ex_mem_read=1, ex_valid=1), ID = ADD rs=5 → stall=1 that cycle. Next cycle: ex_valid=0 and all control bits 0, stall=0, then the ADD loads. With MIPS_HAZARD_CNT_EN, bubble_cnt=1.
- LW rt=0 in EX, ID rs=0 → stall=0, no bubble. LW rt=7, ID = ADDI rt=7 rs=4 (alu_src=1) → stall=0.
- flush=1 together with hazard=1 → stall=0, one bubble, bubble_cnt unchanged.
- hold=1 for 3 cycles with BEQ in ID → ex_* unchanged for 3 cycles; BEQ loads (ex_branch=1, ex_alu_op=2'b01) on the cycle hold drops.
- rst_n=0 asserted during a stall → next cycle all ex_*=0 and stall=0; id_valid=0 with id_reg_write=1 → ex_reg_write=0.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared constants for the MIPS pipeline slice: ALU operation class
//   encodings, register index width, the hard-wired zero register index,
//   and the bit layout of the packed decoder control bundle.
//   pack_ctrl() builds the packed bundle from individual decoder outputs.
package mips_pkg;

  // ALU operation class, as produced by the main decoder
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;  // loads/stores/address add
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;  // branch compare
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;  // funct field decides
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;  // immediate arithmetic/logic

  // Register file addressing
  localparam int         REG_AW   = 5;
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Packed control bundle layout
  localparam int CTRL_W          = 9;
  localparam int CTRL_REG_DST    = 0;
  localparam int CTRL_ALU_SRC    = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_MEM_WRITE  = 3;
  localparam int CTRL_MEM_TO_REG = 4;
  localparam int CTRL_REG_WRITE  = 5;
  localparam int CTRL_BRANCH     = 6;
  localparam int CTRL_ALU_OP_LO  = 7;
  localparam int CTRL_ALU_OP_HI  = 8;

  // Pack the individual decoder outputs into one control word.
  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic       reg_dst,
    input logic       alu_src,
    input logic       mem_read,
    input logic       mem_write,
    input logic       mem_to_reg,
    input logic       reg_write,
    input logic       branch,
    input logic [1:0] alu_op
  );
    logic [CTRL_W-1:0] w;
    w                                    = '0;
    w[CTRL_REG_DST]                      = reg_dst;
    w[CTRL_ALU_SRC]                      = alu_src;
    w[CTRL_MEM_READ]                     = mem_read;
    w[CTRL_MEM_WRITE]                    = mem_write;
    w[CTRL_MEM_TO_REG]                   = mem_to_reg;
    w[CTRL_REG_WRITE]                    = reg_write;
    w[CTRL_BRANCH]                       = branch;
    w[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO]     = alu_op;
    return w;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
//   Combinational load-use hazard detector. A hazard exists when the
//   instruction now in EX is a valid load whose destination (rt) is a
//   non-zero register that the instruction in ID reads.
//   The ID instruction reads rt when it takes its second ALU operand from
//   the register file (alu_src=0) or when it is a store (rt supplies the
//   store data).
// Ports:
//   i_id_valid, i_id_alu_src, i_id_mem_write, i_id_rs, i_id_rt : ID side
//   i_ex_valid, i_ex_mem_read, i_ex_rt                         : EX side
//   o_hazard                                                   : hazard flag
module load_use_detect
  import mips_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              i_id_valid,
  input  logic              i_id_alu_src,
  input  logic              i_id_mem_write,
  input  logic [REG_AW-1:0] i_id_rs,
  input  logic [REG_AW-1:0] i_id_rt,
  input  logic              i_ex_valid,
  input  logic              i_ex_mem_read,
  input  logic [REG_AW-1:0] i_ex_rt,
  output logic              o_hazard
);

  logic w_uses_rt;
  logic w_ex_rt_nonzero;
  logic w_rs_match;
  logic w_rt_match;

  assign w_uses_rt       = ~i_id_alu_src | i_id_mem_write;
  // Writes to the zero register are discarded, so they never forward.
  assign w_ex_rt_nonzero = (i_ex_rt != REG_AW'(REG_ZERO));
  assign w_rs_match      = (i_ex_rt == i_id_rs);
  assign w_rt_match      = w_uses_rt & (i_ex_rt == i_id_rt);

  assign o_hazard = i_id_valid & i_ex_valid & i_ex_mem_read &
                    w_ex_rt_nonzero & (w_rs_match | w_rt_match);

endmodule

// File: rtl/id_ex_stage_reg.sv
// id_ex_stage_reg
//   ID/EX pipeline boundary register. Latches the decoder control bundle,
//   register operands, sign-extended immediate, PC+4 and register indices
//   from ID into EX, inserts a one-cycle bubble on a load-use hazard and
//   squashes the ID instruction when EX resolves a taken branch.
//
// Flow control (the only handshake in this block):
//   stall is combinational and asserted in the same cycle the hazard is
//   seen; while it is high the PC and IF/ID must not advance, so the ID
//   instruction is re-presented next cycle after the bubble has cleared
//   ex_mem_read. hold freezes every register here (memory wait); flush
//   replaces the ID instruction with a bubble and suppresses stall.
//   Update priority per clock: reset, hold, flush, hazard, normal load.
//   The upstream stage must keep flush asserted for as long as hold is high.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   hold, flush         : freeze / squash controls
//   id_*                : ID stage instruction (valid, control, indices, data)
//   stall               : freeze PC and IF/ID
//   ex_*                : registered EX stage copies of the id_* fields
//   bubble_cnt          : saturating hazard bubble count, only when
//                         MIPS_HAZARD_CNT_EN is defined
module id_ex_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              flush,
  input  logic              id_valid,
  input  logic              id_reg_dst,
  input  logic              id_alu_src,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              id_reg_write,
  input  logic              id_branch,
  input  logic [1:0]        id_alu_op,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [DATA_W-1:0] id_rdata1,
  input  logic [DATA_W-1:0] id_rdata2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [DATA_W-1:0] id_pc4,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_alu_src,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg,
  output logic              ex_reg_write,
  output logic              ex_branch,
  output logic [1:0]        ex_alu_op,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_pc4
`ifdef MIPS_HAZARD_CNT_EN
  ,
  output logic [15:0]       bubble_cnt
`endif
);

  import mips_pkg::*;

  // --------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------
  logic              r_valid;
  logic [CTRL_W-1:0] r_ctrl;
  logic [REG_AW-1:0] r_rs;
  logic [REG_AW-1:0] r_rt;
  logic [REG_AW-1:0] r_rd;
  logic [DATA_W-1:0] r_rdata1;
  logic [DATA_W-1:0] r_rdata2;
  logic [DATA_W-1:0] r_imm;
  logic [DATA_W-1:0] r_pc4;

  // --------------------------------------------------------------------
  // Combinational
  // --------------------------------------------------------------------
  logic [CTRL_W-1:0] w_id_ctrl;
  logic [CTRL_W-1:0] w_id_ctrl_gated;
  logic              w_hazard;
  logic              w_bubble;

  assign w_id_ctrl = pack_ctrl(id_reg_dst, id_alu_src, id_mem_read,
                               id_mem_write, id_mem_to_reg, id_reg_write,
                               id_branch, id_alu_op);

  // An invalid ID slot must never carry side effects into EX, whatever
  // the decoder happens to be driving.
  assign w_id_ctrl_gated = id_valid ? w_id_ctrl : '0;

  load_use_detect #(
    .REG_AW (REG_AW)
  ) u_load_use_detect (
    .i_id_valid     (id_valid),
    .i_id_alu_src   (id_alu_src),
    .i_id_mem_write (id_mem_write),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_valid     (r_valid),
    .i_ex_mem_read  (r_ctrl[CTRL_MEM_READ]),
    .i_ex_rt        (r_rt),
    .o_hazard       (w_hazard)
  );

  // A flushed ID instruction is discarded anyway, so it must not stall.
  // During hold the EX contents are frozen, so stall stays high on its own.
  assign stall = w_hazard & ~flush & rst_n;

  // Flush and hazard both replace the EX slot with a bubble.
  assign w_bubble = flush | w_hazard;

  // --------------------------------------------------------------------
  // Stage register
  // --------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_ctrl   <= '0;          // alu_op field = ALU_OP_ADD
      r_rs     <= '0;
      r_rt     <= '0;
      r_rd     <= '0;
      r_rdata1 <= '0;
      r_rdata2 <= '0;
      r_imm    <= '0;
      r_pc4    <= '0;
    end else if (!hold) begin
      if (w_bubble) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end else begin
        r_valid <= id_valid;
        r_ctrl  <= w_id_ctrl_gated;
      end
      // Data fields of a bubble are don't-care; loading them keeps the
      // datapath enable simple (only hold gates it).
      r_rs     <= id_rs;
      r_rt     <= id_rt;
      r_rd     <= id_rd;
      r_rdata1 <= id_rdata1;
      r_rdata2 <= id_rdata2;
      r_imm    <= id_imm;
      r_pc4    <= id_pc4;
    end
  end

`ifdef MIPS_HAZARD_CNT_EN
  // Counts hazard bubbles only (not flush bubbles); saturates at all-ones.
  logic [15:0] r_bubble_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_cnt <= '0;
    end else if (!hold && !flush && w_hazard && (r_bubble_cnt != 16'hFFFF)) begin
      r_bubble_cnt <= r_bubble_cnt + 16'd1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
`endif

  // --------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------
  assign ex_valid      = r_valid;
  assign ex_reg_dst    = r_ctrl[CTRL_REG_DST];
  assign ex_alu_src    = r_ctrl[CTRL_ALU_SRC];
  assign ex_mem_read   = r_ctrl[CTRL_MEM_READ];
  assign ex_mem_write  = r_ctrl[CTRL_MEM_WRITE];
  assign ex_mem_to_reg = r_ctrl[CTRL_MEM_TO_REG];
  assign ex_reg_write  = r_ctrl[CTRL_REG_WRITE];
  assign ex_branch     = r_ctrl[CTRL_BRANCH];
  assign ex_alu_op     = r_ctrl[CTRL_ALU_OP_HI:CTRL_ALU_OP_LO];
  assign ex_rs         = r_rs;
  assign ex_rt         = r_rt;
  assign ex_rd         = r_rd;
  assign ex_rdata1     = r_rdata1;
  assign ex_rdata2     = r_rdata2;
  assign ex_imm        = r_imm;
  assign ex_pc4        = r_pc4;

endmodule
